// File: rtl/uart_rx_ring_buffer_pkg.sv
// uart_rx_ring_buffer_pkg
//   Platform constants and helpers for the UART receive ring buffer.
//   UART_RX_DEPTH_DEFAULT : default number of byte slots in the RX buffer.
//   is_pow2()             : elaboration-time helper for DEPTH sanity checks.
package uart_rx_ring_buffer_pkg;

  localparam int UART_RX_DEPTH_DEFAULT = 64;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_rx_ring_mem.sv
// uart_rx_ring_mem
//   Byte storage for the RX ring buffer: DEPTH x 8, one synchronous write
//   port and one asynchronous read port (LUT/register array), so the parent
//   can present the oldest byte in the same cycle it becomes available.
// Ports:
//   clk   : system clock
//   we    : write enable, wdata is stored at waddr on the rising edge
//   waddr : write slot
//   wdata : byte to store
//   raddr : read slot
//   rdata : contents of raddr (combinational)
module uart_rx_ring_mem #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  // Contents are deliberately not reset; occupancy lives in the parent.
  logic [7:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/uart_rx_ring_buffer.sv
// uart_rx_ring_buffer
//   Circular receive buffer between the UART receiver and the MMIO block.
//   First-word-fall-through: rd_data shows the oldest byte whenever empty=0,
//   so the MMIO block can sample it in the same cycle it pulses rd_en.
// Ports:
//   clk          : system clock
//   rst          : asynchronous active-high reset (clears pointers, count, flags)
//   rx_byte      : byte from the UART receiver
//   rx_valid     : one-cycle strobe qualifying rx_byte
//   rd_en        : consume the oldest byte (ignored while empty)
//   rd_data      : oldest stored byte, 8'h00 while empty
//   empty        : no bytes stored
//   full         : DEPTH bytes stored
//   count        : number of stored bytes, 0..DEPTH
//   overflow     : sticky, a byte was dropped because the buffer was full
//   overflow_clr : clears overflow (a same-cycle drop takes priority)
module uart_rx_ring_buffer
  import uart_rx_ring_buffer_pkg::*;
#(
  parameter  int DEPTH  = UART_RX_DEPTH_DEFAULT,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_byte,
  input  logic            rx_valid,
  input  logic            rd_en,
  output logic [7:0]      rd_data,
  output logic            empty,
  output logic            full,
  output logic [ADDR_W:0] count,
  output logic            overflow,
  input  logic            overflow_clr
);

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              overflow_reg, overflow_next;

  logic       rd;
  logic       wr;
  logic       drop;
  logic [7:0] mem_rdata;

  // empty/full derive only from the registered count, so there is no
  // combinational path from any input to them.
  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_COUNT);

  assign rd   = rd_en && !empty;
  // A write into a full buffer is still accepted when a read frees a slot
  // in the same cycle.
  assign wr   = rx_valid && (!full || rd);
  assign drop = rx_valid && full && !rd_en;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;

    if (wr) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (rd) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end

    if (wr && !rd) begin
      count_next = count_reg + CNT_ONE;
    end else if (rd && !wr) begin
      count_next = count_reg - CNT_ONE;
    end

    // Set beats clear so a drop coinciding with overflow_clr is not lost.
    if (drop) begin
      overflow_next = 1'b1;
    end else if (overflow_clr) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  uart_rx_ring_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr),
    .waddr (wr_ptr_reg),
    .wdata (rx_byte),
    .raddr (rd_ptr_reg),
    .rdata (mem_rdata)
  );

  // Never-written slots must not leak X downstream; while empty (including
  // during reset) the output is forced to zero. No bypass from rx_byte.
  assign rd_data  = empty ? 8'h00 : mem_rdata;
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_rx_ring_buffer.sv
// tb_uart_rx_ring_buffer
//   Self-checking bench for uart_rx_ring_buffer (DEPTH=64). A queue-based
//   reference model tracks the expected contents and overflow flag.
module tb_uart_rx_ring_buffer;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [6:0] count;
  logic       overflow;
  logic       overflow_clr;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q[$];
  bit         model_ovf;

  always #5 clk = ~clk;

  uart_rx_ring_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  // One transaction: apply inputs, take one clock edge, update the model
  // from the queue occupancy seen before the edge, then idle the inputs.
  task automatic drive(input bit v, input logic [7:0] b, input bit r, input bit c);
    bit rd_ok;
    bit wr_ok;
    rx_valid     = v;
    rx_byte      = b;
    rd_en        = r;
    overflow_clr = c;
    @(posedge clk);
    rd_ok = r && (model_q.size() != 0);
    wr_ok = v && ((model_q.size() < DEPTH) || rd_ok);
    if (v && !wr_ok) model_ovf = 1'b1;
    else if (c)      model_ovf = 1'b0;
    if (rd_ok) void'(model_q.pop_front());
    if (wr_ok) model_q.push_back(b);
    #1;
    rx_valid     = 1'b0;
    rd_en        = 1'b0;
    overflow_clr = 1'b0;
    $display("txn v=%0b byte=%02h rd=%0b clr=%0b -> count=%0d empty=%0b full=%0b ovf=%0b rd_data=%02h",
             v, b, r, c, count, empty, full, overflow, rd_data);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; rd_en = 1'b0; overflow_clr = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    #2;
    checks++; if (count !== 7'd0)   begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL reset_empty got %0b want 1", empty); end
    checks++; if (full !== 1'b0)    begin errors++; $display("FAIL reset_full got %0b want 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %02h want 00", rd_data); end
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_basic_order();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
    end
    checks++; if (count !== 7'd3) begin errors++; $display("FAIL basic_count got %0d want 3", count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic_empty got %0b want 0", empty); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_data !== 8'h41 + 8'(i)) begin
        errors++; $display("FAIL basic_data%0d got %02h want %02h", i, rd_data, 8'h41 + 8'(i));
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty_end got %0b want 1", empty); end
    checks++; if (count !== 7'd0) begin errors++; $display("FAIL basic_count_end got %0d want 0", count); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    checks++; if (full !== 1'b1)   begin errors++; $display("FAIL fill_full got %0b want 1", full); end
    checks++; if (count !== 7'd64) begin errors++; $display("FAIL fill_count got %0d want 64", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got %0b want 0", overflow); end
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got %0b want 1", overflow); end
    checks++; if (count !== 7'd64)   begin errors++; $display("FAIL fill_count_drop got %0d want 64", count); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (rd_data !== 8'(i)) begin errors++; $display("FAIL fill_drain%0d got %02h want %02h", i, rd_data, 8'(i)); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_empty_end got %0b want 1", empty); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_clr got %0b want 0", overflow); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 40; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (rd_data !== model_q[0]) begin errors++; $display("FAIL wrap_a%0d got %02h want %02h", i, rd_data, model_q[0]); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    for (int i = 0; i < 40; i++) drive(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    checks++; if (count !== 7'd40) begin errors++; $display("FAIL wrap_count got %0d want 40", count); end
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (rd_data !== 8'h80 + 8'(i)) begin errors++; $display("FAIL wrap_b%0d got %02h want %02h", i, rd_data, 8'h80 + 8'(i)); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (count !== 7'd0) begin errors++; $display("FAIL wrap_count_end got %0d want 0", count); end
  endtask

  task automatic test_full_simul();
    logic [7:0] last;
    last = 8'h00;
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    checks++; if (count !== 7'd64)   begin errors++; $display("FAIL simul_count got %0d want 64", count); end
    checks++; if (full !== 1'b1)     begin errors++; $display("FAIL simul_full got %0b want 1", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_ovf got %0b want 0", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (rd_data !== model_q[0]) begin errors++; $display("FAIL simul_drain%0d got %02h want %02h", i, rd_data, model_q[0]); end
      last = rd_data;
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (last !== 8'h55) begin errors++; $display("FAIL simul_last got %02h want 55", last); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (count !== 7'd0) begin errors++; $display("FAIL empty_rd_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL empty_rd_empty got %0b want 1", empty); end
    drive(1'b1, 8'h7E, 1'b0, 1'b0);
    checks++; if (rd_data !== 8'h7E) begin errors++; $display("FAIL empty_rd_data got %02h want 7e", rd_data); end
    checks++; if (count !== 7'd1)    begin errors++; $display("FAIL empty_rd_count1 got %0d want 1", count); end
    // count=1: write and read in the same cycle, the new byte falls through
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    checks++; if (count !== 7'd1)    begin errors++; $display("FAIL b2b_count got %0d want 1", count); end
    checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL b2b_data got %02h want a5", rd_data); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %0b want 1", empty); end
  endtask

  task automatic test_overflow_clr_and_async_reset();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", overflow); end
    drive(1'b1, 8'h22, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %0b want 1", overflow); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %0b want 0", overflow); end
    for (int i = 0; i < DEPTH - 10; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (count !== 7'd10) begin errors++; $display("FAIL pre_rst_count got %0d want 10", count); end
    // Mid-cycle reset: must take effect before the next clock edge.
    #2;
    rst = 1'b1;
    #1;
    checks++; if (count !== 7'd0) begin errors++; $display("FAIL async_rst_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL async_rst_empty got %0b want 1", empty); end
    model_q.delete();
    model_ovf = 1'b0;
    #3;
    rst = 1'b0;
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL post_rst_data got %02h want 3c", rd_data); end
    checks++; if (count !== 7'd1)    begin errors++; $display("FAIL post_rst_count got %0d want 1", count); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    bit v, r, c;
    for (int i = 0; i < 400; i++) begin
      // Alternate write-heavy and read-heavy phases to reach full and empty.
      if ((i / 100) % 2 == 0) begin
        v = ($urandom_range(99) < 80);
        r = ($urandom_range(99) < 25);
      end else begin
        v = ($urandom_range(99) < 25);
        r = ($urandom_range(99) < 80);
      end
      c = ($urandom_range(99) < 5);
      if (model_q.size() != 0) begin
        checks++;
        if (rd_data !== model_q[0]) begin errors++; $display("FAIL rand_data%0d got %02h want %02h", i, rd_data, model_q[0]); end
      end
      drive(v, 8'($urandom), r, c);
      checks++;
      if (count !== 7'(model_q.size())) begin errors++; $display("FAIL rand_count%0d got %0d want %0d", i, count, model_q.size()); end
      checks++;
      if (empty !== (model_q.size() == 0)) begin errors++; $display("FAIL rand_empty%0d got %0b want %0b", i, empty, model_q.size() == 0); end
      checks++;
      if (full !== (model_q.size() == DEPTH)) begin errors++; $display("FAIL rand_full%0d got %0b want %0b", i, full, model_q.size() == DEPTH); end
      checks++;
      if (overflow !== model_ovf) begin errors++; $display("FAIL rand_ovf%0d got %0b want %0b", i, overflow, model_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_fill_overflow();
    test_wrap();
    test_full_simul();
    test_back_to_back();
    test_overflow_clr_and_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ring_buffer.md
Name: uart_rx_ring_buffer

Overview:
Circular receive buffer between the UART receiver (byte + strobe) and the MMIO peripheral block.
- Stores received bytes until the CPU reads them via the UART RX DATA register; the MMIO block consumes rd_data, rd_en and empty.
- Output is first-word-fall-through: rd_data shows the oldest byte whenever empty=0, because the MMIO block samples data in the same cycle it pulses rd_en.
- Provides occupancy count and a sticky overflow flag for software diagnostics.

Parameters:
DEPTH, 64, number of byte slots; must be a power of two, 2..256.
ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
clk  input  1  system clock; the block has one clock.
rst  input  1  reset, asynchronous and active-high.
rx_byte  input  8  byte from UART receiver.
rx_valid  input  1  one-cycle strobe: rx_byte is valid.
rd_en  input  1  consume oldest byte (pulse from MMIO block).
rd_data  output  8  oldest stored byte, valid when empty=0.
empty  output  1  buffer holds zero bytes.
full  output  1  buffer holds DEPTH bytes.
count  output  ADDR_W+1  number of stored bytes, 0..DEPTH.
overflow  output  1  sticky: a byte was dropped because the buffer was full.
overflow_clr  input  1  clears overflow.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst=1:
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, overflow=0.
  - rd_data is don't-care but must not be X-propagating; drive 8'h00.
  - Storage contents are not cleared.
- Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0. Count is a separate ADDR_W+1 register; empty = (count==0), full = (count==DEPTH), both registered or derived from the registered count (no combinational path from inputs).
- Write accept: wr = rx_valid && (!full || rd). On wr, mem[wr_ptr] <= rx_byte and wr_ptr increments.
- Read accept: rd = rd_en && !empty. On rd, rd_ptr increments. rd_en while empty is ignored: no pointer or count change, no error flag.
- Count update: +1 on wr only, -1 on rd only, unchanged when both or neither occur.
- Simultaneous write and read when full: both are accepted, count stays DEPTH, no overflow.
- Simultaneous write and read when count=1: both are accepted, count stays 1, and rd_data shows the new byte in the next cycle.
- Overflow: rx_valid && full && !rd_en drops the byte and sets overflow=1 in the next cycle. Pointers and count are unchanged.
- overflow_clr=1 clears overflow next cycle. If a drop occurs in the same cycle, set wins and overflow stays 1.
- Latency:
  - A byte written at edge N is visible (empty=0, rd_data valid) after edge N; the MMIO block may read it in cycle N+1.
  - After rd at edge N, rd_data shows the next byte after edge N.
  - There is no bypass from rx_byte to rd_data while empty.
- rd_data = mem[rd_ptr], read combinationally from storage (LUT/register array). Do not use a registered-output BRAM unless an output-prefetch stage preserves FWFT timing.
- Reset asserted mid-stream discards all contents immediately (asynchronous). After release, the first rx_valid writes slot 0.

Decomposition:
- No shared package is required. DEPTH and ADDR_W are local to this module; the RX buffer depth default belongs with the platform constants if one exists.
- One sub-module is natural: uart_rx_ring_mem.
  - Storage only: DEPTH x 8, synchronous write port, asynchronous read port.
  - Pointer, count and flag logic stay in the parent.

Test Plan:
1. Reset, then write 0x41, 0x42, 0x43 on three separated strobes -> count=3, empty=0. Three rd_en pulses return 0x41, 0x42, 0x43 in order, and after the third, empty=1, count=0.
2. Write 64 bytes 0x00..0x3F (DEPTH=64) -> full=1, count=64. A 65th write of 0xFF -> overflow=1, count=64. Draining all 64 returns 0x00..0x3F with no 0xFF.
3. Wrap-around: write 40, read 40, write 40 (0x80..0xA7), read 40 -> data 0x80..0xA7 in order, both pointers wrapped, count ends 0.
4. With full=1, pulse rx_valid (0x55) and rd_en in the same cycle -> oldest byte consumed, 0x55 stored, count stays 64, overflow stays 0. The last byte drained is 0x55.
5. rd_en pulses while empty -> count stays 0, no pointer movement. The next write of 0x7E reads back as 0x7E.
6. Overflow set, then overflow_clr coinciding with another dropped write -> overflow stays 1. A later overflow_clr alone -> 0. Asserting rst mid-stream with count=10 -> empty=1, count=0 immediately, without waiting for a clock edge.
